cnt_reg_bank: RTL and testbench
===============================

Name: cnt_reg_bank

Overview:
- Parametrised successor to the single 16-bit incrementable bus register.
- Holds NREG general-purpose registers of WIDTH bits each. Every register supports bus write, increment, decrement and post-increment-on-read (address-pointer use).
- Tri-state bus driver, per-register zero flags, registered wrap/saturate event pulse.
- Sits on the core's shared data BUS; used for pointer and loop-counter registers.

Parameters:
- WIDTH, 16, data width of each register and of the bus.
- NREG, 4, number of registers; must be >= 2.
- SEL_W, $clog2(NREG), register-select width (derived, not overridden).
- STEP, 1, increment/decrement amount; must satisfy 1 <= STEP < 2**WIDTH.
- SAT, 0, 0 = modular wrap on overflow/underflow; 1 = saturate at max/0.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- BIN  input  WIDTH  bus data for writes.
- WR  input  1  write BIN into register WSEL.
- WSEL  input  SEL_W  write target.
- INC  input  1  add STEP to register CSEL.
- DEC  input  1  subtract STEP from register CSEL.
- CSEL  input  SEL_W  count target.
- LDBUS  input  1  drive register RSEL onto BOUT.
- RINC  input  1  post-increment register RSEL after the read; honoured only with LDBUS=1.
- RSEL  input  SEL_W  read target.
- BOUT  output  WIDTH  tri-state bus output.
- ZERO  output  NREG  ZERO[i]=1 when register i == 0.
- WRAP  output  1  one-cycle pulse: previous edge's count wrapped, or was clamped when SAT=1.

Behaviour:
- Reset (RST=1 at posedge): all registers <= 0, WRAP <= 0. Other inputs ignored that cycle. Reset mid-operation discards any pending count, write or post-increment.
- After reset: ZERO = all ones. BOUT = 'z while LDBUS=0.
- BOUT is combinational: LDBUS=1 -> reg[RSEL] (pre-edge value); LDBUS=0 -> all 'z. Zero latency.
- Out-of-range select (value >= NREG, non-power-of-2 NREG):
  - write/count/post-inc is a no-op;
  - read drives all zeros.
- Per-register update priority at each posedge, applied independently to each register i:
  1. RST.
  2. Count: CSEL==i and INC xor DEC.
     - INC: r + STEP.
     - DEC: r - STEP.
     - INC=DEC=1: no change, no count event.
  3. Write: WR and WSEL==i -> r <= BIN.
  4. Post-increment: LDBUS and RINC and RSEL==i -> r + STEP.
  5. Hold.
- Operations on different registers in the same cycle all take effect. Example: WR to reg 0 plus INC of reg 1 plus post-inc of reg 2 in one cycle.
- Arithmetic:
  - Computed at WIDTH+1 bits; the carry/borrow out defines the overflow/underflow event.
  - SAT=0: result truncated to WIDTH (modular).
  - SAT=1: overflow -> 2**WIDTH-1; underflow -> 0.
- WRAP <= 1 on the edge after any performed count or post-increment produced an overflow/underflow event (in either mode); otherwise 0. Writes never set WRAP.
- Losing operations generate no event. Example: post-inc of the same register overridden by WR does not set WRAP.
- ZERO is combinational from register state.
- No X propagation: every register is defined after the first reset.

Decomposition:
- Shared package cnt_reg_pkg:
  - mode constants SAT_WRAP=0, SAT_CLAMP=1;
  - function for the step/saturate computation, returning {event, result}.
- One natural sub-module: cnt_reg_cell, a single register with its priority logic, ZERO and event output. It is instantiated NREG times by generate.
- Top level contains:
  - select decode;
  - read mux + tri-state;
  - WRAP OR-reduction register.

Test Plan:
- Reset then idle -> all regs 0, ZERO=4'b1111, WRAP=0, BOUT='z.
- WR=1 WSEL=2 BIN=16'h1234; next cycle LDBUS=1 RSEL=2 -> BOUT=16'h1234, ZERO=4'b1011.
- Reg1=16'hFFFF, INC CSEL=1 -> SAT=0: reg1=0, WRAP pulses one cycle. SAT=1: reg1=16'hFFFF, WRAP pulses.
- Reg0=0, DEC CSEL=0 -> SAT=0: 16'hFFFF, WRAP=1. Then INC=DEC=1 -> unchanged, WRAP=0.
- Reg3=16'h0100, LDBUS=1 RINC=1 RSEL=3 for 3 cycles -> BOUT reads 0100, 0101, 0102; reg3 ends at 16'h0103. Same cycle WR to reg3 with BIN=16'h0005 -> reg3=0005, no increment.
- Same cycle: INC CSEL=1, WR WSEL=1 BIN=16'h00AA, with RST=1 -> all regs 0. Repeated with RST=0 -> reg1 = old+1 (count beats write).

Source files
------------

// File: rtl/cnt_reg_pkg.sv
// Shared constants, cell operation encoding and step/saturate arithmetic
// for the counter register bank.
package cnt_reg_pkg;

  localparam int unsigned MAX_W     = 64;
  localparam int unsigned SAT_WRAP  = 0;
  localparam int unsigned SAT_CLAMP = 1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_WRITE,
    OP_UP,
    OP_DOWN
  } cell_op_e;

  typedef struct packed {
    logic             ev;
    logic [MAX_W-1:0] res;
  } step_res_t;

  // Arithmetic is done one bit wider than the register so the carry/borrow
  // is visible; width must not exceed MAX_W.
  function automatic step_res_t step_calc(
    input logic [MAX_W-1:0] val,
    input logic [MAX_W-1:0] step,
    input logic             up,
    input logic             clamp,
    input int unsigned      width
  );
    logic [MAX_W:0] lim;
    logic [MAX_W:0] mask;
    logic [MAX_W:0] full;
    step_res_t      o;
    lim  = (MAX_W+1)'(1) << width;
    mask = lim - (MAX_W+1)'(1);
    if (up) full = {1'b0, val} + {1'b0, step};
    else    full = {1'b0, val} - {1'b0, step};
    o.ev = up ? (full >= lim) : (val < step);
    if (o.ev && clamp) full = up ? mask : '0;
    full  = full & mask;
    o.res = full[MAX_W-1:0];
    return o;
  endfunction

endpackage

// File: rtl/cnt_reg_bank_if.sv
// Control/data bundle between the core and the counter register bank.
interface cnt_reg_bank_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 4
);
  localparam int unsigned SEL_W = $clog2(NREG);

  logic [WIDTH-1:0] BIN;
  logic             WR;
  logic [SEL_W-1:0] WSEL;
  logic             INC;
  logic             DEC;
  logic [SEL_W-1:0] CSEL;
  logic             LDBUS;
  logic             RINC;
  logic [SEL_W-1:0] RSEL;
  logic [NREG-1:0]  ZERO;
  logic             WRAP;

  modport master (
    output BIN, WR, WSEL, INC, DEC, CSEL, LDBUS, RINC, RSEL,
    input  ZERO, WRAP
  );

  modport slave (
    input  BIN, WR, WSEL, INC, DEC, CSEL, LDBUS, RINC, RSEL,
    output ZERO, WRAP
  );

endinterface

// File: rtl/cnt_reg_cell.sv
// One bank register: count > write > post-increment > hold, with zero flag
// and a combinational wrap/clamp event for the winning operation.
module cnt_reg_cell
  import cnt_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  parameter int unsigned SAT   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pinc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_zero,
  output logic             o_ev
);

  logic [WIDTH-1:0] r_q;
  cell_op_e         w_op;
  step_res_t        w_step;

  always_comb begin
    w_op = OP_HOLD;
    if (i_inc ^ i_dec) w_op = i_inc ? OP_UP : OP_DOWN;
    else if (i_wr)     w_op = OP_WRITE;
    else if (i_pinc)   w_op = OP_UP;
  end

  always_comb begin
    w_step = step_calc(MAX_W'(r_q), MAX_W'(STEP), (w_op == OP_UP),
                       (SAT == SAT_CLAMP), WIDTH);
  end

  // Only an arithmetic operation that actually wins may raise an event.
  assign o_ev   = ((w_op == OP_UP) || (w_op == OP_DOWN)) && w_step.ev;
  assign o_q    = r_q;
  assign o_zero = (r_q == '0);

  if (WIDTH < MAX_W) begin : g_unused
    logic w_unused_hi;
    assign w_unused_hi = |w_step.res[MAX_W-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_q <= '0;
    end else begin
      case (w_op)
        OP_UP, OP_DOWN: r_q <= w_step.res[WIDTH-1:0];
        OP_WRITE:       r_q <= i_wdata;
        default:        r_q <= r_q;
      endcase
    end
  end

endmodule

// File: rtl/cnt_reg_bank.sv
// Bank of NREG incrementable bus registers with tri-state read port,
// per-register zero flags and a registered wrap/clamp pulse.
module cnt_reg_bank
  import cnt_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 4,
  parameter int unsigned STEP  = 1,
  parameter int unsigned SAT   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             RST,
  cnt_reg_bank_if.slave    bus,
  output logic [WIDTH-1:0] BOUT
);

  localparam int unsigned SEL_W = $clog2(NREG);

  logic             w_count;
  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_dec;
  logic [NREG-1:0]  w_wr;
  logic [NREG-1:0]  w_pinc;
  logic [NREG-1:0]  w_zero;
  logic [NREG-1:0]  w_ev;
  logic [WIDTH-1:0] w_q [NREG];
  logic [WIDTH-1:0] w_rd;
  logic             r_wrap;

  assign w_count = bus.INC ^ bus.DEC;

  // Selects beyond NREG-1 match no cell, so they are no-ops and read as zero.
  always_comb begin
    w_inc  = '0;
    w_dec  = '0;
    w_wr   = '0;
    w_pinc = '0;
    w_rd   = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_inc[i]  = w_count && bus.INC && (bus.CSEL == SEL_W'(i));
      w_dec[i]  = w_count && bus.DEC && (bus.CSEL == SEL_W'(i));
      w_wr[i]   = bus.WR && (bus.WSEL == SEL_W'(i));
      w_pinc[i] = bus.LDBUS && bus.RINC && (bus.RSEL == SEL_W'(i));
      if (bus.RSEL == SEL_W'(i)) w_rd = w_q[i];
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cell
    cnt_reg_cell #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .SAT   (SAT)
    ) u_cell (
      .clk     (clk),
      .RST     (RST),
      .i_inc   (w_inc[g]),
      .i_dec   (w_dec[g]),
      .i_wr    (w_wr[g]),
      .i_wdata (bus.BIN),
      .i_pinc  (w_pinc[g]),
      .o_q     (w_q[g]),
      .o_zero  (w_zero[g]),
      .o_ev    (w_ev[g])
    );
  end

  always_ff @(posedge clk) begin
    if (RST) r_wrap <= 1'b0;
    else     r_wrap <= |w_ev;
  end

  assign BOUT     = bus.LDBUS ? w_rd : 'z;
  assign bus.ZERO = w_zero;
  assign bus.WRAP = r_wrap;

endmodule

// File: tb/tb_cnt_reg_bank.sv
// Three bank configurations driven in lockstep and checked every cycle
// against an arithmetic model of the register contents.
module tb_cnt_reg_bank;
  import cnt_reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnt_reg_bank_if #(.WIDTH(16), .NREG(4)) bus_a ();
  cnt_reg_bank_if #(.WIDTH(16), .NREG(4)) bus_b ();
  cnt_reg_bank_if #(.WIDTH(16), .NREG(3)) bus_c ();

  wire [15:0] bout_a;
  wire [15:0] bout_b;
  wire [15:0] bout_c;

  assign bus_b.BIN = bus_a.BIN;     assign bus_c.BIN = bus_a.BIN;
  assign bus_b.WR = bus_a.WR;       assign bus_c.WR = bus_a.WR;
  assign bus_b.WSEL = bus_a.WSEL;   assign bus_c.WSEL = bus_a.WSEL;
  assign bus_b.INC = bus_a.INC;     assign bus_c.INC = bus_a.INC;
  assign bus_b.DEC = bus_a.DEC;     assign bus_c.DEC = bus_a.DEC;
  assign bus_b.CSEL = bus_a.CSEL;   assign bus_c.CSEL = bus_a.CSEL;
  assign bus_b.LDBUS = bus_a.LDBUS; assign bus_c.LDBUS = bus_a.LDBUS;
  assign bus_b.RINC = bus_a.RINC;   assign bus_c.RINC = bus_a.RINC;
  assign bus_b.RSEL = bus_a.RSEL;   assign bus_c.RSEL = bus_a.RSEL;

  cnt_reg_bank #(.WIDTH(16), .NREG(4), .STEP(1), .SAT(SAT_WRAP)) u_dut_a (
    .clk(clk), .RST(rst), .bus(bus_a), .BOUT(bout_a));
  cnt_reg_bank #(.WIDTH(16), .NREG(4), .STEP(1), .SAT(SAT_CLAMP)) u_dut_b (
    .clk(clk), .RST(rst), .bus(bus_b), .BOUT(bout_b));
  cnt_reg_bank #(.WIDTH(16), .NREG(3), .STEP(3), .SAT(SAT_WRAP)) u_dut_c (
    .clk(clk), .RST(rst), .bus(bus_c), .BOUT(bout_c));

  int cfg_n    [3] = '{4, 4, 3};
  int cfg_step [3] = '{1, 1, 3};
  bit cfg_sat  [3] = '{0, 1, 0};

  longint mr    [3][4];
  bit     mwrap [3];
  bit     armed = 1'b0;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each register is a plain integer; out-of-range results wrap or clamp.
  always @(posedge clk) begin
    longint t;
    bit     ev;
    bit     ar;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) mr[k][i] = 0;
        mwrap[k] = 1'b0;
      end else begin
        ev = 1'b0;
        for (int i = 0; i < cfg_n[k]; i++) begin
          ar = 1'b0;
          t  = 0;
          if ((bus_a.INC != bus_a.DEC) && (bus_a.CSEL == i)) begin
            ar = 1'b1;
            t  = bus_a.INC ? mr[k][i] + cfg_step[k] : mr[k][i] - cfg_step[k];
          end else if (bus_a.WR && (bus_a.WSEL == i)) begin
            mr[k][i] = bus_a.BIN;
          end else if (bus_a.LDBUS && bus_a.RINC && (bus_a.RSEL == i)) begin
            ar = 1'b1;
            t  = mr[k][i] + cfg_step[k];
          end
          if (ar) begin
            if (t > 65535) begin
              ev = 1'b1;
              mr[k][i] = cfg_sat[k] ? 65535 : t - 65536;
            end else if (t < 0) begin
              ev = 1'b1;
              mr[k][i] = cfg_sat[k] ? 0 : t + 65536;
            end else begin
              mr[k][i] = t;
            end
          end
        end
        mwrap[k] = ev;
      end
    end
  end

  task automatic cmp_cfg(input int k, input logic [3:0] zero, input logic wrap,
                         input logic [15:0] bout);
    logic [3:0]  ez;
    logic [15:0] eb;
    ez = '0;
    for (int i = 0; i < cfg_n[k]; i++) ez[i] = (mr[k][i] == 0);
    chk($sformatf("zero_cfg%0d", k), 64'(zero), 64'(ez));
    chk($sformatf("wrap_cfg%0d", k), 64'(wrap), 64'(mwrap[k]));
    if (bus_a.LDBUS) begin
      eb = (bus_a.RSEL < cfg_n[k]) ? 16'(mr[k][bus_a.RSEL]) : 16'h0000;
      chk($sformatf("bout_cfg%0d", k), 64'(bout), 64'(eb));
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp_cfg(0, bus_a.ZERO, bus_a.WRAP, bout_a);
      cmp_cfg(1, bus_b.ZERO, bus_b.WRAP, bout_b);
      cmp_cfg(2, {1'b0, bus_c.ZERO}, bus_c.WRAP, bout_c);
    end
  end

  task automatic idle();
    rst = 1'b0;
    bus_a.BIN = '0; bus_a.WR = 1'b0; bus_a.WSEL = '0;
    bus_a.INC = 1'b0; bus_a.DEC = 1'b0; bus_a.CSEL = '0;
    bus_a.LDBUS = 1'b0; bus_a.RINC = 1'b0; bus_a.RSEL = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int sel);
    idle();
    bus_a.LDBUS = 1'b1;
    bus_a.RSEL  = 2'(sel);
  endtask

  task automatic wr(input int sel, input logic [15:0] d);
    idle();
    bus_a.WR = 1'b1; bus_a.WSEL = 2'(sel); bus_a.BIN = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    armed = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("reset_zero_a", 64'(bus_a.ZERO), 64'h0F);
    chk("reset_zero_c", 64'(bus_c.ZERO), 64'h07);
    chk("reset_wrap_a", 64'(bus_a.WRAP), 64'h0);

    wr(2, 16'h1234); tick();
    rd(2);
    @(negedge clk);
    chk("wr_rd_reg2", 64'(bout_a), 64'h1234);
    chk("wr_zero_a", 64'(bus_a.ZERO), 64'hB);

    wr(1, 16'hFFFF); tick();
    idle(); bus_a.INC = 1'b1; bus_a.CSEL = 2'd1; tick();
    rd(1);
    @(negedge clk);
    chk("ovf_wrap_a", 64'(bus_a.WRAP), 64'h1);
    chk("ovf_wrap_b", 64'(bus_b.WRAP), 64'h1);
    chk("ovf_val_a", 64'(bout_a), 64'h0000);
    chk("ovf_val_b", 64'(bout_b), 64'hFFFF);
    chk("ovf_zero_a", 64'(bus_a.ZERO), 64'hB);
    tick();
    @(negedge clk);
    chk("ovf_wrap_drop", 64'(bus_a.WRAP), 64'h0);

    idle(); bus_a.DEC = 1'b1; bus_a.CSEL = 2'd0; tick();
    rd(0);
    @(negedge clk);
    chk("udf_wrap_a", 64'(bus_a.WRAP), 64'h1);
    chk("udf_val_a", 64'(bout_a), 64'hFFFF);
    chk("udf_val_b", 64'(bout_b), 64'h0000);
    idle(); bus_a.INC = 1'b1; bus_a.DEC = 1'b1; bus_a.CSEL = 2'd0; tick();
    rd(0);
    @(negedge clk);
    chk("incdec_wrap", 64'(bus_a.WRAP), 64'h0);
    chk("incdec_val", 64'(bout_a), 64'hFFFF);

    wr(3, 16'h0100); tick();
    rd(3); bus_a.RINC = 1'b1;
    @(negedge clk); chk("pinc_rd0", 64'(bout_a), 64'h0100);
    tick();
    @(negedge clk); chk("pinc_rd1", 64'(bout_a), 64'h0101);
    tick();
    @(negedge clk); chk("pinc_rd2", 64'(bout_a), 64'h0102);
    tick();
    bus_a.WR = 1'b1; bus_a.WSEL = 2'd3; bus_a.BIN = 16'h0005;
    @(negedge clk); chk("pinc_rd3", 64'(bout_a), 64'h0103);
    tick();
    rd(3);
    @(negedge clk);
    chk("wr_beats_pinc", 64'(bout_a), 64'h0005);
    chk("wr_beats_pinc_wrap", 64'(bus_a.WRAP), 64'h0);

    wr(1, 16'h00AA); bus_a.INC = 1'b1; bus_a.CSEL = 2'd1; rst = 1'b1; tick();
    idle();
    @(negedge clk);
    chk("rst_prio_a", 64'(bus_a.ZERO), 64'hF);
    chk("rst_prio_c", 64'(bus_c.ZERO), 64'h7);
    wr(1, 16'h0010); tick();
    wr(1, 16'h00AA); bus_a.INC = 1'b1; bus_a.CSEL = 2'd1; tick();
    rd(1);
    @(negedge clk);
    chk("cnt_beats_wr_a", 64'(bout_a), 64'h0011);
    chk("cnt_beats_wr_c", 64'(bout_c), 64'h0013);
    wr(3, 16'h0077); tick();
    rd(3);
    @(negedge clk);
    chk("oor_rd_a", 64'(bout_a), 64'h0077);
    chk("oor_rd_c", 64'(bout_c), 64'h0000);
    chk("oor_zero_c", 64'(bus_c.ZERO), 64'h5);

    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      bus_a.WR   = ($urandom_range(0, 3) == 0);
      bus_a.WSEL = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       bus_a.BIN = 16'hFFFF - 16'($urandom_range(0, 3));
        1:       bus_a.BIN = 16'($urandom_range(0, 3));
        default: bus_a.BIN = 16'($urandom);
      endcase
      bus_a.INC   = 1'($urandom_range(0, 1));
      bus_a.DEC   = ($urandom_range(0, 2) == 0);
      bus_a.CSEL  = 2'($urandom_range(0, 3));
      bus_a.LDBUS = 1'($urandom_range(0, 1));
      bus_a.RINC  = 1'($urandom_range(0, 1));
      bus_a.RSEL  = 2'($urandom_range(0, 3));
      tick();
    end
    idle();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
